pipe_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage CPU. Sits beside the forwarding logic and drives the enables and flushes of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three cases:
- load-use hazards that forwarding cannot cover;
- taken branches resolved in EX;
- multi-cycle data-memory accesses, with a timeout fault.

---
 rtl/pipe_pkg.sv | 9 +
 rtl/pipe_lu_detect.sv | 20 ++
 rtl/pipe_hazard_ctrl.sv | 91 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and defaults for the pipeline hazard controller.
//   state_t          - controller FSM states (RUN, MEM_WAIT, FAULT)
//   PIPE_REG_AW      - default register-address width
//   PIPE_MEM_TIMEOUT - default max consecutive memory wait cycles
package pipe_pkg;
  localparam int PIPE_REG_AW = 4;
  localparam int PIPE_MEM_TIMEOUT = 255;
  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;
endpackage

// File: rtl/pipe_lu_detect.sv
// pipe_lu_detect: combinational load-use hazard comparator.
//   ex_memrd_i          - EX-stage instruction is a load
//   ex_dest_i           - EX-stage destination register
//   id_rs_a_i/id_rs_b_i - ID-stage source registers
//   id_use_a_i/b_i      - ID instruction actually reads that source
//   lu_o                - load-use hazard (register 0 is not exempt)
module pipe_lu_detect import pipe_pkg::*; #(
  parameter int REG_AW = PIPE_REG_AW
) (
  input  logic              ex_memrd_i,
  input  logic [REG_AW-1:0] ex_dest_i,
  input  logic [REG_AW-1:0] id_rs_a_i,
  input  logic [REG_AW-1:0] id_rs_b_i,
  input  logic              id_use_a_i,
  input  logic              id_use_b_i,
  output logic              lu_o
);
  assign lu_o = ex_memrd_i & ((id_use_a_i & (ex_dest_i == id_rs_a_i)) |
                              (id_use_b_i & (ex_dest_i == id_rs_b_i)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline hazard controller (load-use, taken branch, memory wait/timeout).
//   inputs : ID sources/use flags, EX load/dest/branch-taken, MEM req/ready
//   outputs: pc/ifid/idex/exmem load enables, ifid/idex/memwb flushes, sticky fault
//   PIPE_PERF_CNT_EN: adds stall_cycles, a saturating count of cycles with pc_en=0
module pipe_hazard_ctrl import pipe_pkg::*; #(
  parameter int REG_AW = PIPE_REG_AW,
  parameter int MEM_TIMEOUT = PIPE_MEM_TIMEOUT,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs_a,
  input  logic [REG_AW-1:0] id_rs_b,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic              ex_memrd,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              memwb_flush,
  output logic              fault
`ifdef PIPE_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cycles
`endif
);
  state_t state_q, state_d;
  logic [15:0] wait_q, wait_d;
  logic mem_stall, lu;
  assign mem_stall = mem_req & ~mem_ready;
  pipe_lu_detect #(.REG_AW(REG_AW)) u_lu (
    .ex_memrd_i(ex_memrd),
    .ex_dest_i(ex_dest),
    .id_rs_a_i(id_rs_a),
    .id_rs_b_i(id_rs_b),
    .id_use_a_i(id_use_a),
    .id_use_b_i(id_use_b),
    .lu_o(lu)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= RUN;
      wait_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
    end
  // wait_d is the number of consecutive stall cycles including this one, so the
  // FSM enters FAULT right after the MEM_TIMEOUT-th stall cycle.
  always_comb begin
    state_d = state_q;
    wait_d = wait_q;
    pc_en = 1'b0;
    ifid_en = 1'b0;
    idex_en = 1'b0;
    exmem_en = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    memwb_flush = 1'b0;
    fault = (state_q == FAULT) & ~rst;
    if (state_q != FAULT && !rst) begin
      if (mem_stall) begin
        memwb_flush = 1'b1;
        wait_d = (state_q == RUN) ? 16'd1 : wait_q + 16'd1;
        state_d = (wait_d == 16'(MEM_TIMEOUT)) ? FAULT : MEM_WAIT;
      end else begin
        wait_d = '0;
        state_d = RUN;
        pc_en = ex_branch_taken | ~lu;
        ifid_en = ex_branch_taken | ~lu;
        idex_en = 1'b1;
        exmem_en = 1'b1;
        ifid_flush = ex_branch_taken;
        idex_flush = ex_branch_taken | lu;
      end
    end
  end
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_q <= '0;
    else if (!pc_en && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
  assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios plus randomized traffic against a cycle-count reference model.
module tb_pipe_hazard_ctrl;
  localparam int TO = 4;
  localparam logic [7:0] E_NONE = 8'b1111_0000;
  localparam logic [7:0] E_LU = 8'b0011_0100;
  localparam logic [7:0] E_BR = 8'b1111_1100;
  localparam logic [7:0] E_WAIT = 8'b0000_0010;
  localparam logic [7:0] E_FAULT = 8'b0000_0001;
  localparam logic [7:0] E_RST = 8'b0000_0000;
  typedef struct packed {
    logic rq, rd, br, mr, ua, ub;
    logic [3:0] dst, ra, rb;
  } stim_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] id_rs_a = '0, id_rs_b = '0, ex_dest = '0;
  logic id_use_a = 1'b0, id_use_b = 1'b0, ex_memrd = 1'b0, ex_branch_taken = 1'b0;
  logic mem_req = 1'b0, mem_ready = 1'b0;
  logic pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush, fault;
  logic [7:0] obs;
  int tests = 0, fails = 0;
  assign obs = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush, fault};
  always #5 clk = ~clk;
  pipe_hazard_ctrl #(.REG_AW(4), .MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs_a(id_rs_a), .id_rs_b(id_rs_b), .id_use_a(id_use_a), .id_use_b(id_use_b),
    .ex_memrd(ex_memrd), .ex_dest(ex_dest), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
    .fault(fault)
  );
  function automatic stim_t st(logic rq, logic rd, logic br, logic mr, logic ua, logic ub,
                               logic [3:0] dst, logic [3:0] ra, logic [3:0] rb);
    return '{rq: rq, rd: rd, br: br, mr: mr, ua: ua, ub: ub, dst: dst, ra: ra, rb: rb};
  endfunction
  task automatic apply(input stim_t s);
    mem_req = s.rq; mem_ready = s.rd; ex_branch_taken = s.br; ex_memrd = s.mr;
    id_use_a = s.ua; id_use_b = s.ub; ex_dest = s.dst; id_rs_a = s.ra; id_rs_b = s.rb;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  localparam stim_t IDLE = '0;
  task automatic test_reset;
    apply(IDLE);
    #1;
    tests++;
    if (obs !== E_RST) begin fails++; $display("FAIL reset_hold: got %b want %b", obs, E_RST); end
    tick(); tick();
    tests++;
    if (obs !== E_RST) begin fails++; $display("FAIL reset_hold_clk: got %b want %b", obs, E_RST); end
    rst = 1'b0;
    #1;
    tests++;
    if (obs !== E_NONE) begin fails++; $display("FAIL reset_release: got %b want %b", obs, E_NONE); end
    tick();
  endtask
  task automatic run_seq(input string name, input stim_t s[$], input logic [7:0] e[$]);
    foreach (s[i]) begin
      apply(s[i]);
      #1;
      tests++;
      if (obs !== e[i]) begin fails++; $display("FAIL %s step%0d: got %b want %b", name, i, obs, e[i]); end
      tick();
    end
  endtask
  task automatic test_load_use;
    stim_t s[$];
    logic [7:0] e[$];
    s.push_back(st(0,0,0,1,1,0,5,5,0)); e.push_back(E_LU);
    s.push_back(st(0,0,0,0,1,0,5,5,0)); e.push_back(E_NONE);
    s.push_back(st(0,0,0,1,0,1,0,3,0)); e.push_back(E_LU);
    s.push_back(st(0,0,0,0,0,1,0,3,0)); e.push_back(E_NONE);
    s.push_back(st(0,0,0,1,0,0,5,5,5)); e.push_back(E_NONE);
    s.push_back(st(0,0,0,1,1,1,6,5,7)); e.push_back(E_NONE);
    run_seq("load_use", s, e);
  endtask
  task automatic test_branch_lu;
    stim_t s[$];
    logic [7:0] e[$];
    s.push_back(st(0,0,1,1,1,0,5,5,0)); e.push_back(E_BR);
    s.push_back(st(0,0,0,0,0,0,0,0,0)); e.push_back(E_NONE);
    s.push_back(st(0,0,1,0,0,0,0,0,0)); e.push_back(E_BR);
    run_seq("branch_lu", s, e);
  endtask
  task automatic test_mem_wait;
    stim_t s[$];
    logic [7:0] e[$];
    repeat (3) begin s.push_back(st(1,0,0,0,0,0,0,0,0)); e.push_back(E_WAIT); end
    s.push_back(st(1,1,0,0,0,0,0,0,0)); e.push_back(E_NONE);
    s.push_back(IDLE); e.push_back(E_NONE);
    run_seq("mem_wait", s, e);
  endtask
  task automatic test_branch_wait;
    stim_t s[$];
    logic [7:0] e[$];
    repeat (2) begin s.push_back(st(1,0,1,0,0,0,0,0,0)); e.push_back(E_WAIT); end
    s.push_back(st(1,1,1,0,0,0,0,0,0)); e.push_back(E_BR);
    s.push_back(IDLE); e.push_back(E_NONE);
    run_seq("branch_wait", s, e);
  endtask
  task automatic test_back_to_back;
    stim_t s[$];
    logic [7:0] e[$];
    repeat (3) begin s.push_back(st(1,0,0,0,0,0,0,0,0)); e.push_back(E_WAIT); end
    s.push_back(st(1,1,0,0,0,0,0,0,0)); e.push_back(E_NONE);
    repeat (3) begin s.push_back(st(1,0,0,0,0,0,0,0,0)); e.push_back(E_WAIT); end
    s.push_back(st(0,0,0,0,0,0,0,0,0)); e.push_back(E_NONE);
    run_seq("back_to_back", s, e);
  endtask
  task automatic test_timeout;
    stim_t s[$];
    logic [7:0] e[$];
    repeat (TO) begin s.push_back(st(1,0,0,0,0,0,0,0,0)); e.push_back(E_WAIT); end
    s.push_back(st(1,0,0,0,0,0,0,0,0)); e.push_back(E_FAULT);
    s.push_back(st(1,1,1,0,0,0,0,0,0)); e.push_back(E_FAULT);
    s.push_back(IDLE); e.push_back(E_FAULT);
    run_seq("timeout", s, e);
    pulse_reset();
    #1;
    tests++;
    if (obs !== E_NONE) begin fails++; $display("FAIL timeout_clear: got %b want %b", obs, E_NONE); end
    tick();
  endtask
  task automatic test_async_reset;
    apply(st(1,0,0,0,0,0,0,0,0));
    tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (obs !== E_RST) begin fails++; $display("FAIL async_rst_mid: got %b want %b", obs, E_RST); end
    apply(IDLE);
    #1;
    rst = 1'b0;
    #1;
    tests++;
    if (obs !== E_NONE) begin fails++; $display("FAIL async_rst_release: got %b want %b", obs, E_NONE); end
    tick();
    begin
      stim_t s[$];
      logic [7:0] e[$];
      repeat (3) begin s.push_back(st(1,0,0,0,0,0,0,0,0)); e.push_back(E_WAIT); end
      s.push_back(IDLE); e.push_back(E_NONE);
      run_seq("async_rst_after", s, e);
    end
  endtask
  task automatic test_random;
    int run = 0;
    bit faulted = 0;
    for (int c = 0; c < 600; c++) begin
      stim_t s;
      logic [7:0] exp;
      bit stall, hz;
      if (c % 97 == 96) begin
        rst = 1'b1;
        #1;
        tests++;
        if (obs !== E_RST) begin fails++; $display("FAIL random_rst c%0d: got %b want %b", c, obs, E_RST); end
        tick();
        rst = 1'b0;
        run = 0;
        faulted = 0;
      end
      s.rq = ($urandom_range(0, 99) < 45);
      s.rd = ($urandom_range(0, 99) < 40);
      s.br = ($urandom_range(0, 99) < 15);
      s.mr = ($urandom_range(0, 99) < 50);
      s.ua = 1'($urandom);
      s.ub = 1'($urandom);
      s.dst = 4'($urandom_range(0, 3));
      s.ra = 4'($urandom_range(0, 3));
      s.rb = 4'($urandom_range(0, 3));
      apply(s);
      stall = s.rq && !s.rd;
      hz = s.mr && ((s.ua && s.dst == s.ra) || (s.ub && s.dst == s.rb));
      exp = faulted ? E_FAULT : stall ? E_WAIT : s.br ? E_BR : hz ? E_LU : E_NONE;
      #1;
      tests++;
      if (obs !== exp) begin fails++; $display("FAIL random c%0d: got %b want %b", c, obs, exp); end
      tick();
      if (!faulted) begin
        run = stall ? run + 1 : 0;
        if (run == TO) faulted = 1;
      end
    end
  endtask
  initial begin
    test_reset();
    test_load_use();
    test_branch_lu();
    test_mem_wait();
    test_branch_wait();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    pulse_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
